// File: rtl/reg_writeback_if.sv
// Bundles the memory-stage input, register-file write port, hazard lookup and
// retire counter for reg_writeback. The slave modport is the writeback block.
interface reg_writeback_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic             RegDst;
  logic             RegWrite;
  logic             MemToReg;
  logic [31:0]      alu_result;
  logic [31:0]      mem_data;
  logic [1:0]       addr_lo;
  logic             rf_busy;
  logic             reg_we;
  logic [4:0]       reg_waddr;
  logic [31:0]      reg_wdata;
  logic [4:0]       lookup_reg;
  logic             lookup_hit;
  logic [CNT_W-1:0] retired;

  modport master (
    output in_valid, opcode, rt, rd, RegDst, RegWrite, MemToReg,
           alu_result, mem_data, addr_lo, rf_busy, lookup_reg,
    input  in_ready, reg_we, reg_waddr, reg_wdata, lookup_hit, retired
  );

  modport slave (
    input  in_valid, opcode, rt, rd, RegDst, RegWrite, MemToReg,
           alu_result, mem_data, addr_lo, rf_busy, lookup_reg,
    output in_ready, reg_we, reg_waddr, reg_wdata, lookup_hit, retired
  );
endinterface

// File: rtl/reg_writeback.sv
// Register writeback stage: formats load data, queues writes in a small FIFO
// and drains them to the register file one per cycle unless it is busy.
module reg_writeback #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  reg_writeback_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t           fifo_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             we_q;
  logic [4:0]       waddr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] retired_q;

  logic [4:0]  dest;
  logic [31:0] src;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt;
  logic        store;
  logic        pop;
  logic        hit;
  logic [PW-1:0] off;

  assign bus.in_ready   = (count != FULL);
  assign bus.reg_we     = we_q;
  assign bus.reg_waddr  = waddr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.retired    = retired_q;
  assign bus.lookup_hit = hit;

  // Instructions that write nothing, or only write r0, are swallowed on accept.
  always_comb begin
    dest  = bus.RegDst ? bus.rd : bus.rt;
    src   = bus.MemToReg ? bus.mem_data : bus.alu_result;
    store = bus.in_valid && bus.in_ready && bus.RegWrite && (dest != 5'd0);
    pop   = (count != '0) && !bus.rf_busy;
  end

  always_comb begin
    byte_sel = src[7:0];
    case (bus.addr_lo)
      2'd0: byte_sel = src[7:0];
      2'd1: byte_sel = src[15:8];
      2'd2: byte_sel = src[23:16];
      2'd3: byte_sel = src[31:24];
      default: byte_sel = src[7:0];
    endcase
    half_sel = bus.addr_lo[1] ? src[31:16] : src[15:0];
    fmt = src;
    case (bus.opcode)
      OP_LB:        fmt = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:       fmt = {24'd0, byte_sel};
      OP_LH:        fmt = {{16{half_sel[15]}}, half_sel};
      OP_LHU:       fmt = {16'd0, half_sel};
      OP_LW, OP_LL: fmt = src;
      default:      fmt = src;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store) begin
      fifo_mem[wr_ptr] <= '{dest: dest, data: fmt};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The write port registers hold their last value when nothing is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      retired_q <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        waddr_q   <= fifo_mem[rd_ptr].dest;
        wdata_q   <= fifo_mem[rd_ptr].data;
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (fifo_mem[i].dest == bus.lookup_reg)) begin
        hit = 1'b1;
      end
    end
    if (we_q && (waddr_q == bus.lookup_reg)) hit = 1'b1;
    if (bus.lookup_reg == 5'd0) hit = 1'b0;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected writes are queued when driven
// and matched against every register-file strobe in order.
module tb_reg_writeback;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_writeback_if #(.CNT_W(CNT_W)) bus ();

  reg_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [36:0] exp_q[$];
  int model_retired = 0;
  int strobe_count  = 0;
  int first_cyc     = 0;
  int last_cyc      = 0;
  int cyc           = 0;
  int retired_snap;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && bus.reg_we) begin
      strobe_count++;
      if (strobe_count == 1) first_cyc = cyc;
      last_cyc = cyc;
      model_retired = (model_retired + 1) % (1 << CNT_W);
      checkOutput("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("waddr", 32'(bus.reg_waddr), 32'(e[36:32]));
        checkOutput("wdata", bus.reg_wdata, e[31:0]);
      end
      checkOutput("retired", 32'(bus.retired), 32'(model_retired));
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rt_v, input logic [4:0] rd_v,
                               input logic rdst, input logic rwr, input logic mtr,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [1:0] alo, input logic [31:0] exp_data);
    logic ready;
    logic [4:0] d;
    bus.in_valid   = 1'b1;
    bus.opcode     = op;
    bus.rt         = rt_v;
    bus.rd         = rd_v;
    bus.RegDst     = rdst;
    bus.RegWrite   = rwr;
    bus.MemToReg   = mtr;
    bus.alu_result = alu;
    bus.mem_data   = mem;
    bus.addr_lo    = alo;
    ready = bus.in_ready;
    d = rdst ? rd_v : rt_v;
    @(posedge clk);
    if (ready && rwr && (d != 5'd0)) exp_q.push_back({d, exp_data});
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    exp_q.delete();
    model_retired = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;   bus.opcode = '0;     bus.rt = '0;       bus.rd = '0;
    bus.RegDst = 1'b0;     bus.RegWrite = 1'b0; bus.MemToReg = 1'b0;
    bus.alu_result = '0;   bus.mem_data = '0;   bus.addr_lo = '0;
    bus.rf_busy = 1'b0;    bus.lookup_reg = 5'd5;
    rst = 1'b1;
    #1;
    checkOutput("rst_ready",   32'(bus.in_ready),   32'd1);
    checkOutput("rst_we",      32'(bus.reg_we),     32'd0);
    checkOutput("rst_waddr",   32'(bus.reg_waddr),  32'd0);
    checkOutput("rst_wdata",   bus.reg_wdata,       32'd0);
    checkOutput("rst_retired", 32'(bus.retired),    32'd0);
    checkOutput("rst_hit",     32'(bus.lookup_hit), 32'd0);
    bus.lookup_reg = 5'd0;
    doReset();

    // LBU latency: strobe appears in the cycle after the pop edge
    applyStimulus(6'h24, 5'd5, 5'd9, 1'b0, 1'b1, 1'b1, 32'h0, 32'hA1B2C3D4, 2'd2, 32'h000000B2);
    checkOutput("lbu_we_early", 32'(bus.reg_we), 32'd0);
    @(posedge clk); #1;
    checkOutput("lbu_we",    32'(bus.reg_we),    32'd1);
    checkOutput("lbu_waddr", 32'(bus.reg_waddr), 32'd5);
    checkOutput("lbu_wdata", bus.reg_wdata,      32'h000000B2);
    bus.lookup_reg = 5'd5; #1;
    checkOutput("hit_strobe", 32'(bus.lookup_hit), 32'd1);
    bus.lookup_reg = 5'd0;
    drain();

    // Formatting table, issued back to back
    applyStimulus(6'h20, 5'd6,  5'd0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h00000080, 2'd0, 32'hFFFFFF80);
    applyStimulus(6'h21, 5'd7,  5'd0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h80011234, 2'd2, 32'hFFFF8001);
    applyStimulus(6'h23, 5'd2,  5'd31, 1'b1, 1'b1, 1'b1, 32'h12345678, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF);
    applyStimulus(6'h25, 5'd8,  5'd0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h80011234, 2'd3, 32'h00008001);
    applyStimulus(6'h25, 5'd8,  5'd0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h80011234, 2'd1, 32'h00001234);
    applyStimulus(6'h24, 5'd9,  5'd0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h80011234, 2'd3, 32'h00000080);
    applyStimulus(6'h20, 5'd9,  5'd0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h80011234, 2'd1, 32'h00000012);
    applyStimulus(6'h30, 5'd1,  5'd9,  1'b1, 1'b1, 1'b1, 32'h0,        32'hCAFEF00D, 2'd2, 32'hCAFEF00D);
    applyStimulus(6'h00, 5'd1,  5'd10, 1'b1, 1'b1, 1'b0, 32'h1234ABCD, 32'hFFFFFFFF, 2'd0, 32'h1234ABCD);
    applyStimulus(6'h20, 5'd11, 5'd0,  1'b0, 1'b1, 1'b0, 32'h000000FF, 32'h0,        2'd0, 32'hFFFFFFFF);
    applyStimulus(6'h21, 5'd12, 5'd0,  1'b0, 1'b1, 1'b1, 32'h0,        32'h0000FFFE, 2'd0, 32'hFFFFFFFE);
    drain();

    // Back-pressure fills the FIFO, then releases in order
    bus.rf_busy = 1'b1;
    applyStimulus(6'h00, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 32'd7, 32'h0, 2'd0, 32'd7);
    applyStimulus(6'h00, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'd9, 32'h0, 2'd0, 32'd9);
    checkOutput("full_ready", 32'(bus.in_ready), 32'd0);
    bus.lookup_reg = 5'd4; #1;
    checkOutput("hit_q4", 32'(bus.lookup_hit), 32'd1);
    bus.lookup_reg = 5'd3; #1;
    checkOutput("hit_q3", 32'(bus.lookup_hit), 32'd1);
    bus.lookup_reg = 5'd6; #1;
    checkOutput("miss_q6", 32'(bus.lookup_hit), 32'd0);
    bus.lookup_reg = 5'd0;
    applyStimulus(6'h00, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 2'd0, 32'h99);
    checkOutput("full_hold_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("busy_no_we",      32'(bus.reg_we),   32'd0);
    bus.rf_busy = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_we1",    32'(bus.reg_we),    32'd1);
    checkOutput("bp_waddr1", 32'(bus.reg_waddr), 32'd3);
    checkOutput("bp_wdata1", bus.reg_wdata,      32'd7);
    checkOutput("bp_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    checkOutput("bp_we2",    32'(bus.reg_we),    32'd1);
    checkOutput("bp_waddr2", 32'(bus.reg_waddr), 32'd4);
    checkOutput("bp_wdata2", bus.reg_wdata,      32'd9);
    drain();

    // Dropped instructions never strobe or count
    retired_snap = int'(bus.retired);
    applyStimulus(6'h00, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 2'd0, 32'h55);
    applyStimulus(6'h00, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 2'd0, 32'h55);
    repeat (3) @(posedge clk); #1;
    checkOutput("drop_we",      32'(bus.reg_we),  32'd0);
    checkOutput("drop_retired", 32'(bus.retired), 32'(retired_snap));
    bus.lookup_reg = 5'd0; #1;
    checkOutput("drop_hit_r0",  32'(bus.lookup_hit), 32'd0);

    // Counter wrap: 17 contiguous writes leave a 4-bit counter at 1
    doReset();
    strobe_count = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(6'h00, 5'd0, 5'(i + 1), 1'b1, 1'b1, 1'b0, 32'(i * 3 + 1), 32'h0, 2'd0, 32'(i * 3 + 1));
    end
    drain();
    checkOutput("wrap_count",   32'(strobe_count),             32'd17);
    checkOutput("wrap_contig",  32'(last_cyc - first_cyc + 1), 32'd17);
    checkOutput("wrap_retired", 32'(bus.retired),              32'd1);

    // Asynchronous reset while the FIFO is full
    bus.rf_busy = 1'b1;
    applyStimulus(6'h00, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 2'd0, 32'd1);
    applyStimulus(6'h00, 5'd0, 5'd14, 1'b1, 1'b1, 1'b0, 32'd2, 32'h0, 2'd0, 32'd2);
    checkOutput("pre_rst_ready", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_ready",   32'(bus.in_ready), 32'd1);
    checkOutput("mid_rst_we",      32'(bus.reg_we),   32'd0);
    checkOutput("mid_rst_retired", 32'(bus.retired),  32'd0);
    bus.lookup_reg = 5'd13; #1;
    checkOutput("mid_rst_hit", 32'(bus.lookup_hit), 32'd0);
    bus.lookup_reg = 5'd0;
    exp_q.delete();
    model_retired = 0;
    bus.rf_busy = 1'b0;
    strobe_count = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    checkOutput("post_rst_strobes", 32'(strobe_count), 32'd0);
    checkOutput("post_rst_retired", 32'(bus.retired),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-side producer for the 32x32 register file: accepts completed instructions from the memory stage and issues single-cycle register write pulses.
- Formats load data for LB/LBU/LH/LHU/LW/LL and selects the RT or RD destination.
- Buffers results in a small FIFO, honours a register-file busy back-pressure signal, and reports pending destinations for hazard stalling.

Parameters:
- DEPTH, 2, FIFO entries (power of two, 2..8).
- CNT_W, 16, width of retired-write counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  memory stage presents an instruction.
- in_ready  output  1  block can accept; equals !full.
- opcode  input  6  instruction opcode.
- rt  input  5  RT field.
- rd  input  5  RD field.
- RegDst  input  1  1 = write RD, 0 = write RT.
- RegWrite  input  1  instruction writes a register.
- MemToReg  input  1  1 = source is mem_data, 0 = alu_result.
- alu_result  input  32  ALU result.
- mem_data  input  32  aligned memory word.
- addr_lo  input  2  low address bits for sub-word loads.
- rf_busy  input  1  register file cannot accept a write this cycle.
- reg_we  output  1  write strobe to register file.
- reg_waddr  output  5  write register index.
- reg_wdata  output  32  write data.
- lookup_reg  input  5  register queried by decode.
- lookup_hit  output  1  lookup_reg matches a pending write.
- retired  output  CNT_W  count of writes issued.

Behaviour:
- Reset (async, any time): FIFO emptied; reg_we=0, reg_waddr=0, reg_wdata=0, retired=0, in_ready=1. Any in-flight entry is discarded.
- Push: on rising clk when in_valid && in_ready.
  - Entries with RegWrite=0 are accepted and dropped; they are not stored.
  - Destination index is known as dest, selected by RegDst. Entries with dest==0 are also dropped.
- Formatting before storage; selected data is mem_data if MemToReg, else alu_result. Little-endian lane select, byte b = addr_lo, half h = addr_lo[1].
  - 0x20 LB: sign-extend byte b.
  - 0x24 LBU: zero-extend byte b.
  - 0x21 LH: sign-extend half h.
  - 0x25 LHU: zero-extend half h.
  - 0x23 LW, 0x30 LL, and all other opcodes: full 32 bits.
  - addr_lo[0]=1 on LH/LHU is ignored; half h is still used.
- Pop: on rising clk when FIFO non-empty && !rf_busy.
  - Head entry is loaded into the reg_waddr/reg_wdata registers; reg_we=1 for exactly that following cycle.
  - If no pop occurs: reg_we=0, and reg_waddr/reg_wdata hold their previous values.
- Latency: push at edge k into an empty FIFO with rf_busy low → pop at edge k+1 → reg_we high during cycle k+1..k+2. Minimum latency is 2 edges.
- Throughput: one write per cycle while rf_busy stays low.
- Occupancy and ready:
  - Count tracks push and pop; simultaneous push and pop leaves the count unchanged.
  - in_ready depends only on registered occupancy, never on rf_busy in the same cycle. When full, no push occurs even if a pop happens that cycle.
  - Read and write pointers wrap modulo DEPTH.
- rf_busy high: no pop; the FIFO holds and fills. When full, in_ready=0 until the first cycle after a pop.
- lookup_hit (combinational) is 1 if lookup_reg != 0 and it matches:
  - any valid FIFO entry's dest, or
  - reg_waddr while reg_we=1.
  - Otherwise lookup_hit is 0.
- retired increments by 1 at every edge that sets reg_we=1 and wraps at 2^CNT_W.
- Ordering: writes leave in push order. Two pending writes to the same register produce two strobes, oldest first.

Test Plan:
- Reset mid-stream: DEPTH=2, FIFO full, assert rst → same cycle in_ready=1, reg_we=0, retired=0; no strobe after release.
- LBU opcode 0x24, MemToReg=1, mem_data=0xA1B2C3D4, addr_lo=2, RegDst=0, rt=5 → one reg_we pulse, reg_waddr=5, reg_wdata=0x000000B2, 2 edges after push.
- LB at addr_lo=0 with mem_data=0x00000080 → 0xFFFFFF80. LH at addr_lo=2 with mem_data=0x8001_1234 → 0xFFFF8001. LW RegDst=1 rd=31 alu-independent → full word to reg 31.
- Back-pressure: rf_busy=1, push 2 ALU results (rd=3 value 7, rd=4 value 9) → in_ready=0 after second push, lookup_reg=4 gives hit=1. Release rf_busy → strobes reg3=7 then reg4=9 on consecutive cycles; in_ready=1 the cycle after the first pop.
- Drops: RegWrite=0, or RegDst=1 with rd=0, value 0x55 → no reg_we, retired unchanged, lookup_reg=0 gives hit=0.
- Counter wrap: CNT_W=4, 17 back-to-back writes → retired=1; all strobes contiguous with rf_busy=0.
